// File: rtl/paddsb_accum_ctrl_if.sv
// Operand stream and job-control bundle between the issue logic (master)
// and the saturating accumulator sequencer (slave).
interface paddsb_accum_ctrl_if;
    logic        start;
    logic [4:0]  len;
    logic        busy;
    logic        err;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        done;
    logic [15:0] result;
    logic [3:0]  sat_flags;

    modport master (
        output start, len, in_valid, in_data,
        input  busy, err, in_ready, done, result, sat_flags
    );

    modport slave (
        input  start, len, in_valid, in_data,
        output busy, err, in_ready, done, result, sat_flags
    );
endinterface

// File: rtl/paddsb_accum_ctrl.sv
// Multi-beat PADDSB accumulator: four signed 4-bit saturating lanes summed over a job.
// Optional sticky per-lane saturation flags are built when PADDSB_SAT_FLAGS_EN is defined.

module PADDSB_16bit (
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] Sum
);
    for (genvar k = 0; k < 4; k++) begin : g_lane
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] raw;
        logic       pos_ovf;
        logic       neg_ovf;

        assign a       = A[4*k +: 4];
        assign b       = B[4*k +: 4];
        assign raw     = a + b;
        assign pos_ovf = ~a[3] & ~b[3] &  raw[3];
        assign neg_ovf =  a[3] &  b[3] & ~raw[3];
        assign Sum[4*k +: 4] = pos_ovf ? 4'h7 : (neg_ovf ? 4'h8 : raw);
    end
endmodule

module paddsb_accum_ctrl #(
    parameter int MAX_LEN = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    paddsb_accum_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [4:0] MAX_LEN_V = 5'(MAX_LEN);

    state_t      state;
    state_t      state_next;
    logic [15:0] acc;
    logic [15:0] sum;
    logic [4:0]  cnt;
    logic [15:0] result_q;
    logic        err_q;
    logic        len_ok;
    logic        launch;
    logic        beat;
    logic        last_beat;

    PADDSB_16bit u_paddsb (
        .A   (acc),
        .B   (bus.in_data),
        .Sum (sum)
    );

    assign len_ok    = (bus.len != 5'd0) && (bus.len <= MAX_LEN_V);
    assign launch    = (state == IDLE) && bus.start && len_ok;
    assign beat      = (state == ACCUM) && bus.in_valid;
    assign last_beat = beat && (cnt == 5'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (launch) state_next = ACCUM;
            ACCUM:   if (last_beat) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= 16'h0000;
            cnt      <= 5'd0;
            result_q <= 16'h0000;
            err_q    <= 1'b0;
        end else begin
            err_q <= (state == IDLE) && bus.start && !len_ok;
            if (launch) begin
                acc <= 16'h0000;
                cnt <= bus.len;
            end else if (beat) begin
                acc <= sum;
                cnt <= cnt - 5'd1;
                if (last_beat) begin
                    result_q <= sum;
                end
            end
        end
    end

`ifdef PADDSB_SAT_FLAGS_EN
    logic [3:0] flg;
    logic [3:0] ovf;
    logic [3:0] sat_q;

    // Flags use an independent raw-sum sign test rather than inspecting Sum.
    for (genvar k = 0; k < 4; k++) begin : g_ovf
        logic [3:0] raw;
        assign raw    = acc[4*k +: 4] + bus.in_data[4*k +: 4];
        assign ovf[k] = (acc[4*k+3] == bus.in_data[4*k+3]) && (raw[3] != acc[4*k+3]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flg   <= 4'h0;
            sat_q <= 4'h0;
        end else if (launch) begin
            flg <= 4'h0;
        end else if (beat) begin
            flg <= flg | ovf;
            if (last_beat) begin
                sat_q <= flg | ovf;
            end
        end
    end

    assign bus.sat_flags = sat_q;
`else
    assign bus.sat_flags = 4'h0;
`endif

    assign bus.busy     = (state != IDLE);
    assign bus.in_ready = (state == ACCUM);
    assign bus.done     = (state == DONE);
    assign bus.err      = err_q;
    assign bus.result   = result_q;
endmodule

// File: tb/tb_paddsb_accum_ctrl.sv
// Self-checking bench for paddsb_accum_ctrl: lane-arithmetic job model compared every
// cycle, plus literal expectations for the directed jobs.
module tb_paddsb_accum_ctrl;
`ifdef PADDSB_SAT_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    bit   cmp_en;

    paddsb_accum_ctrl_if bus ();

    paddsb_accum_ctrl #(.MAX_LEN(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Job-level model: remaining beats, pending done/err pulses, lane sums as integers.
    bit          m_busy;
    bit          m_done;
    bit          m_err;
    int          m_remaining;
    logic [15:0] m_acc;
    logic [3:0]  m_flg;
    logic [15:0] m_result;
    logic [3:0]  m_flags;

    task automatic laneAdd(input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] s, output logic [3:0] f);
        logic signed [3:0] na;
        logic signed [3:0] nb;
        int x;
        s = 16'h0;
        f = 4'h0;
        for (int k = 0; k < 4; k++) begin
            na = a[4*k +: 4];
            nb = b[4*k +: 4];
            x = na + nb;
            if (x > 7) begin
                x = 7;
                f[k] = 1'b1;
            end else if (x < -8) begin
                x = -8;
                f[k] = 1'b1;
            end
            s[4*k +: 4] = 4'(x);
        end
    endtask

    always @(posedge clk) begin
        logic [15:0] s;
        logic [3:0]  f;
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_err = 0; m_remaining = 0;
            m_acc = 16'h0; m_flg = 4'h0; m_result = 16'h0; m_flags = 4'h0;
        end else begin
            m_err = 0;
            if (m_done) begin
                m_done = 0;
                m_busy = 0;
            end else if (!m_busy) begin
                if (bus.start) begin
                    if (bus.len == 0 || bus.len > 16) begin
                        m_err = 1;
                    end else begin
                        m_busy = 1;
                        m_remaining = int'(bus.len);
                        m_acc = 16'h0;
                        m_flg = 4'h0;
                    end
                end
            end else if (bus.in_valid) begin
                laneAdd(m_acc, bus.in_data, s, f);
                m_acc = s;
                m_flg = m_flg | f;
                m_remaining--;
                if (m_remaining == 0) begin
                    m_result = s;
                    m_flags = m_flg;
                    m_done = 1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("busy", 16'(bus.busy), 16'(m_busy));
            checkOutput("in_ready", 16'(bus.in_ready), 16'(m_busy && !m_done));
            checkOutput("done", 16'(bus.done), 16'(m_done));
            checkOutput("err", 16'(bus.err), 16'(m_err));
            checkOutput("result", bus.result, m_result);
            checkOutput("sat_flags", 16'(bus.sat_flags), FLAGS_ON ? 16'(m_flags) : 16'h0);
        end
    end

    task automatic applyStimulus(input logic [4:0] l);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.len   = l;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic sendBeat(input logic [15:0] d, input int gap, input bit poke_start);
        bit rdy;
        bit got;
        for (int g = 0; g < gap; g++) begin
            bus.start = poke_start && (g == 0);
            bus.len   = 5'd2;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            if (rdy) got = 1;
        end
        #1;
        bus.in_valid = 1'b0;
        if (!got) begin
            errors++;
            $display("[TB] FAIL beat_accept timeout: got no in_ready expected in_ready=1");
        end
    endtask

    task automatic waitDone(input string name, input logic [15:0] exp_res, input logic [3:0] exp_flg);
        bit seen;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1;
        end
        checkOutput({name, "_done_seen"}, 16'(seen), 16'h1);
        checkOutput({name, "_result"}, bus.result, exp_res);
        checkOutput({name, "_flags"}, 16'(bus.sat_flags), FLAGS_ON ? 16'(exp_flg) : 16'h0);
    endtask

    task automatic illegalLen(input logic [4:0] l, input logic [15:0] kept);
        applyStimulus(l);
        @(negedge clk);
        checkOutput("err_pulse", 16'(bus.err), 16'h1);
        checkOutput("err_busy", 16'(bus.busy), 16'h0);
        checkOutput("err_ready", 16'(bus.in_ready), 16'h0);
        checkOutput("err_kept_result", bus.result, kept);
        @(negedge clk);
        checkOutput("err_one_cycle", 16'(bus.err), 16'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cmp_en = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.len = 5'd0;
        bus.in_valid = 1'b0;
        bus.in_data = 16'h0;
        @(posedge clk);
        #1;
        cmp_en = 1;
        @(negedge clk);
        checkOutput("reset_busy", 16'(bus.busy), 16'h0);
        checkOutput("reset_result", bus.result, 16'h0000);
        checkOutput("reset_ready", 16'(bus.in_ready), 16'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        applyStimulus(5'd3);
        sendBeat(16'h1111, 0, 0);
        sendBeat(16'h2222, 0, 0);
        sendBeat(16'h3333, 0, 0);
        waitDone("sum3", 16'h6666, 4'h0);

        applyStimulus(5'd2);
        sendBeat(16'h7777, 0, 0);
        sendBeat(16'h7777, 0, 0);
        waitDone("pos_sat", 16'h7777, 4'hF);

        applyStimulus(5'd2);
        sendBeat(16'h8888, 0, 0);
        sendBeat(16'h8888, 0, 0);
        waitDone("neg_sat", 16'h8888, 4'hF);

        applyStimulus(5'd1);
        sendBeat(16'h7F80, 0, 0);
        waitDone("single", 16'h7F80, 4'h0);

        applyStimulus(5'd2);
        sendBeat(16'h7F80, 0, 0);
        sendBeat(16'h0181, 0, 0);
        waitDone("mixed", 16'h7081, 4'b0010);

        applyStimulus(5'd4);
        sendBeat(16'h1234, 0, 0);
        sendBeat(16'h4321, 3, 1);
        sendBeat(16'h7777, 3, 0);
        sendBeat(16'h8001, 3, 1);
        waitDone("gaps", 16'hF777, 4'hF);
        repeat (3) @(posedge clk);

        illegalLen(5'd0, 16'hF777);
        illegalLen(5'd17, 16'hF777);

        applyStimulus(5'd4);
        sendBeat(16'h1111, 0, 0);
        sendBeat(16'h1111, 0, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_busy", 16'(bus.busy), 16'h0);
        checkOutput("rst_mid_done", 16'(bus.done), 16'h0);
        checkOutput("rst_mid_result", bus.result, 16'h0000);
        checkOutput("rst_mid_flags", 16'(bus.sat_flags), 16'h0);

        applyStimulus(5'd1);
        sendBeat(16'h0001, 0, 0);
        waitDone("post_reset", 16'h0001, 4'h0);
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
